id_stage: RTL and testbench

- RV32I decode stage, directly downstream of the instruction-fetch stage's IF/ID register.
- Contains the decoder, immediate generator, a 32x32 register file with write-through bypass from writeback, and load-use hazard detection.
- Holds the ID/EX pipeline register that feeds the execute stage.
- Branches and jumps resolve in EX; this block only inserts bubbles on flush.

---
 rtl/id_stage.sv | 333 +++++++++++++++++++++++++++++++++
 tb/tb_id_stage.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// RV32I instruction-decode stage.
// Decodes the instruction held in IF/ID, builds its immediate, reads the
// 32x32 register file (with same-cycle bypass from writeback), detects
// load-use hazards against the instruction in EX and registers everything
// into the ID/EX pipeline register. A cleared ID/EX register is a bubble.
module id_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [31:0]     id_instruction_i,
  input  logic [XLEN-1:0] id_pc_i,
  input  logic [XLEN-1:0] id_pc_add4_i,
  input  logic            id_ready_i,
  input  logic            id_exc_addr_i,
  input  logic            wb_we_i,
  input  logic [4:0]      wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  input  logic            stall_i,
  input  logic            flush_i,
  output logic            id_stall_o,
  output logic            ex_valid_o,
  output logic [XLEN-1:0] ex_pc_o,
  output logic [XLEN-1:0] ex_pc_add4_o,
  output logic [XLEN-1:0] ex_rs1_data_o,
  output logic [XLEN-1:0] ex_rs2_data_o,
  output logic [XLEN-1:0] ex_imm_o,
  output logic [4:0]      ex_rs1_o,
  output logic [4:0]      ex_rs2_o,
  output logic [4:0]      ex_rd_o,
  output logic [2:0]      ex_funct3_o,
  output logic [3:0]      ex_alu_op_o,
  output logic [1:0]      ex_a_sel_o,
  output logic            ex_b_imm_o,
  output logic            ex_reg_write_o,
  output logic            ex_mem_read_o,
  output logic            ex_mem_write_o,
  output logic            ex_branch_o,
  output logic            ex_jal_o,
  output logic            ex_jalr_o,
  output logic            ex_illegal_o,
  output logic            ex_exc_addr_o
);

  // Major opcodes; all carry instruction[1:0] = 11.
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

  // Operand A selector encodings.
  localparam logic [1:0] A_RS1  = 2'b00;
  localparam logic [1:0] A_PC   = 2'b01;
  localparam logic [1:0] A_ZERO = 2'b10;

  // Everything the execute stage receives, held as one record so that
  // reset, bubble and hold treat all fields identically.
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_add4;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [3:0]      alu_op;
    logic [1:0]      a_sel;
    logic            b_imm;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            jal;
    logic            jalr;
    logic            illegal;
    logic            exc_addr;
  } idex_t;

  // Instruction fields.
  logic [6:0] opcode;
  logic [4:0] rd_f;
  logic [4:0] rs1_f;
  logic [4:0] rs2_f;
  logic [2:0] funct3;
  logic       funct7_b5;

  assign opcode    = id_instruction_i[6:0];
  assign rd_f      = id_instruction_i[11:7];
  assign funct3    = id_instruction_i[14:12];
  assign rs1_f     = id_instruction_i[19:15];
  assign rs2_f     = id_instruction_i[24:20];
  assign funct7_b5 = id_instruction_i[30];

  // Sign-extended immediates for each RV32I format.
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;

  assign imm_i = {{(XLEN-12){id_instruction_i[31]}}, id_instruction_i[31:20]};
  assign imm_s = {{(XLEN-12){id_instruction_i[31]}}, id_instruction_i[31:25],
                  id_instruction_i[11:7]};
  assign imm_b = {{(XLEN-13){id_instruction_i[31]}}, id_instruction_i[31],
                  id_instruction_i[7], id_instruction_i[30:25],
                  id_instruction_i[11:8], 1'b0};
  assign imm_u = {{(XLEN-31){id_instruction_i[31]}}, id_instruction_i[30:12],
                  12'b0};
  assign imm_j = {{(XLEN-21){id_instruction_i[31]}}, id_instruction_i[31],
                  id_instruction_i[19:12], id_instruction_i[20],
                  id_instruction_i[30:21], 1'b0};

  // Register file storage; entry 0 is never written and never read.
  logic [XLEN-1:0] rf [NREGS];

  // Writeback port: writes to x0 are dropped.
  always_ff @(posedge clk_i) begin
    if (wb_we_i && (wb_rd_i != 5'd0)) begin
      rf[wb_rd_i] <= wb_data_i;
    end
  end

  // Read ports: x0 reads zero, a same-cycle writeback to the source wins.
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;

  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (rs1_f != 5'd0) begin
      rs1_data = (wb_we_i && (wb_rd_i == rs1_f)) ? wb_data_i : rf[rs1_f];
    end
    if (rs2_f != 5'd0) begin
      rs2_data = (wb_we_i && (wb_rd_i == rs2_f)) ? wb_data_i : rf[rs2_f];
    end
  end

  // Raw decode of the opcode into control bits, immediate and source usage.
  logic            legal;
  logic            rs1_used;
  logic            rs2_used;
  logic [1:0]      a_sel;
  logic            b_imm;
  logic            reg_write;
  logic            mem_read;
  logic            mem_write;
  logic            branch;
  logic            jal;
  logic            jalr;
  logic [3:0]      alu_op;
  logic [XLEN-1:0] imm;

  always_comb begin
    legal     = 1'b1;
    rs1_used  = 1'b1;
    rs2_used  = 1'b0;
    a_sel     = A_RS1;
    b_imm     = 1'b0;
    reg_write = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    branch    = 1'b0;
    jal       = 1'b0;
    jalr      = 1'b0;
    alu_op    = {funct7_b5, funct3};
    imm       = '0;
    case (opcode)
      OPC_LUI: begin
        rs1_used  = 1'b0;
        a_sel     = A_ZERO;
        b_imm     = 1'b1;
        reg_write = 1'b1;
        alu_op    = 4'b0000;
        imm       = imm_u;
      end
      OPC_AUIPC: begin
        rs1_used  = 1'b0;
        a_sel     = A_PC;
        b_imm     = 1'b1;
        reg_write = 1'b1;
        alu_op    = 4'b0000;
        imm       = imm_u;
      end
      OPC_JAL: begin
        rs1_used  = 1'b0;
        a_sel     = A_PC;
        b_imm     = 1'b1;
        reg_write = 1'b1;
        jal       = 1'b1;
        alu_op    = 4'b0000;
        imm       = imm_j;
      end
      OPC_JALR: begin
        b_imm     = 1'b1;
        reg_write = 1'b1;
        jalr      = 1'b1;
        alu_op    = 4'b0000;
        imm       = imm_i;
      end
      OPC_BRANCH: begin
        rs2_used  = 1'b1;
        branch    = 1'b1;
        alu_op    = 4'b0000;
        imm       = imm_b;
      end
      OPC_LOAD: begin
        b_imm     = 1'b1;
        reg_write = 1'b1;
        mem_read  = 1'b1;
        alu_op    = 4'b0000;
        imm       = imm_i;
      end
      OPC_STORE: begin
        rs2_used  = 1'b1;
        b_imm     = 1'b1;
        mem_write = 1'b1;
        alu_op    = 4'b0000;
        imm       = imm_s;
      end
      OPC_OP_IMM: begin
        b_imm     = 1'b1;
        reg_write = 1'b1;
        alu_op    = {(funct3 == 3'b101) && funct7_b5, funct3};
        imm       = imm_i;
      end
      OPC_OP: begin
        rs2_used  = 1'b1;
        reg_write = 1'b1;
      end
      OPC_MISC_MEM: begin
        alu_op    = 4'b0000;
      end
      default: begin
        legal     = 1'b0;
      end
    endcase
    if (id_instruction_i[1:0] != 2'b11) begin
      legal = 1'b0;
    end
  end

  // Final ID/EX payload: illegal or misfetched instructions lose side effects.
  logic  kill_side;
  idex_t dec;

  always_comb begin
    kill_side     = !legal || id_exc_addr_i;
    dec           = '0;
    dec.valid     = 1'b1;
    dec.pc        = id_pc_i;
    dec.pc_add4   = id_pc_add4_i;
    dec.rs1_data  = rs1_data;
    dec.rs2_data  = rs2_data;
    dec.imm       = imm;
    dec.rs1       = rs1_used ? rs1_f : 5'd0;
    dec.rs2       = rs2_used ? rs2_f : 5'd0;
    dec.funct3    = funct3;
    dec.alu_op    = alu_op;
    dec.a_sel     = a_sel;
    dec.b_imm     = b_imm;
    dec.reg_write = reg_write && !kill_side;
    dec.mem_read  = mem_read && !kill_side;
    dec.mem_write = mem_write && !kill_side;
    dec.branch    = branch && legal;
    dec.jal       = jal && legal;
    dec.jalr      = jalr && legal;
    dec.illegal   = !legal;
    dec.exc_addr  = id_exc_addr_i;
    dec.rd        = dec.reg_write ? rd_f : 5'd0;
  end

  // ID/EX register state.
  idex_t ex_q;
  logic  hz;

  // A load in EX whose destination feeds an operand in ID must wait a cycle.
  assign hz = id_ready_i && ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0) &&
              ((rs1_used && (rs1_f == ex_q.rd)) ||
               (rs2_used && (rs2_f == ex_q.rd)));

  // A flush squashes the instruction anyway, so IF need not be held for it.
  assign id_stall_o = hz && !flush_i;

  // ID/EX update: reset, flush, hold, hazard bubble, empty bubble, then load.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ex_q <= '0;
    end else if (flush_i) begin
      ex_q <= '0;
    end else if (stall_i) begin
      ex_q <= ex_q;
    end else if (hz) begin
      ex_q <= '0;
    end else if (!id_ready_i) begin
      ex_q <= '0;
    end else begin
      ex_q <= dec;
    end
  end

  assign ex_valid_o     = ex_q.valid;
  assign ex_pc_o        = ex_q.pc;
  assign ex_pc_add4_o   = ex_q.pc_add4;
  assign ex_rs1_data_o  = ex_q.rs1_data;
  assign ex_rs2_data_o  = ex_q.rs2_data;
  assign ex_imm_o       = ex_q.imm;
  assign ex_rs1_o       = ex_q.rs1;
  assign ex_rs2_o       = ex_q.rs2;
  assign ex_rd_o        = ex_q.rd;
  assign ex_funct3_o    = ex_q.funct3;
  assign ex_alu_op_o    = ex_q.alu_op;
  assign ex_a_sel_o     = ex_q.a_sel;
  assign ex_b_imm_o     = ex_q.b_imm;
  assign ex_reg_write_o = ex_q.reg_write;
  assign ex_mem_read_o  = ex_q.mem_read;
  assign ex_mem_write_o = ex_q.mem_write;
  assign ex_branch_o    = ex_q.branch;
  assign ex_jal_o       = ex_q.jal;
  assign ex_jalr_o      = ex_q.jalr;
  assign ex_illegal_o   = ex_q.illegal;
  assign ex_exc_addr_o  = ex_q.exc_addr;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: a decode vector table plus directed
// sequences for bypass, x0, load-use, priority, hold and exception paths.
module tb_id_stage;

  logic        clk_i;
  logic        rst_i;
  logic [31:0] id_instruction_i;
  logic [31:0] id_pc_i;
  logic [31:0] id_pc_add4_i;
  logic        id_ready_i;
  logic        id_exc_addr_i;
  logic        wb_we_i;
  logic [4:0]  wb_rd_i;
  logic [31:0] wb_data_i;
  logic        stall_i;
  logic        flush_i;
  logic        id_stall_o;
  logic        ex_valid_o;
  logic [31:0] ex_pc_o;
  logic [31:0] ex_pc_add4_o;
  logic [31:0] ex_rs1_data_o;
  logic [31:0] ex_rs2_data_o;
  logic [31:0] ex_imm_o;
  logic [4:0]  ex_rs1_o;
  logic [4:0]  ex_rs2_o;
  logic [4:0]  ex_rd_o;
  logic [2:0]  ex_funct3_o;
  logic [3:0]  ex_alu_op_o;
  logic [1:0]  ex_a_sel_o;
  logic        ex_b_imm_o;
  logic        ex_reg_write_o;
  logic        ex_mem_read_o;
  logic        ex_mem_write_o;
  logic        ex_branch_o;
  logic        ex_jal_o;
  logic        ex_jalr_o;
  logic        ex_illegal_o;
  logic        ex_exc_addr_o;

  int checks;
  int errors;

  id_stage dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .id_instruction_i(id_instruction_i),
    .id_pc_i         (id_pc_i),
    .id_pc_add4_i    (id_pc_add4_i),
    .id_ready_i      (id_ready_i),
    .id_exc_addr_i   (id_exc_addr_i),
    .wb_we_i         (wb_we_i),
    .wb_rd_i         (wb_rd_i),
    .wb_data_i       (wb_data_i),
    .stall_i         (stall_i),
    .flush_i         (flush_i),
    .id_stall_o      (id_stall_o),
    .ex_valid_o      (ex_valid_o),
    .ex_pc_o         (ex_pc_o),
    .ex_pc_add4_o    (ex_pc_add4_o),
    .ex_rs1_data_o   (ex_rs1_data_o),
    .ex_rs2_data_o   (ex_rs2_data_o),
    .ex_imm_o        (ex_imm_o),
    .ex_rs1_o        (ex_rs1_o),
    .ex_rs2_o        (ex_rs2_o),
    .ex_rd_o         (ex_rd_o),
    .ex_funct3_o     (ex_funct3_o),
    .ex_alu_op_o     (ex_alu_op_o),
    .ex_a_sel_o      (ex_a_sel_o),
    .ex_b_imm_o      (ex_b_imm_o),
    .ex_reg_write_o  (ex_reg_write_o),
    .ex_mem_read_o   (ex_mem_read_o),
    .ex_mem_write_o  (ex_mem_write_o),
    .ex_branch_o     (ex_branch_o),
    .ex_jal_o        (ex_jal_o),
    .ex_jalr_o       (ex_jalr_o),
    .ex_illegal_o    (ex_illegal_o),
    .ex_exc_addr_o   (ex_exc_addr_o)
  );

  // Free-running clock.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic        chk_imm;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [3:0]  alu_op;
    logic        chk_alu;
    logic [1:0]  a_sel;
    logic        b_imm;
    logic        chk_sel;
    logic [6:0]  ctrl;
  } vec_t;

  localparam int NVEC = 14;
  vec_t  vecs  [NVEC];
  string names [NVEC];

  logic [6:0] ctrl_now;
  assign ctrl_now = {ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_branch_o,
                     ex_jal_o, ex_jalr_o, ex_illegal_o};

  logic [194:0] all_ex;
  assign all_ex = {ex_valid_o, ex_pc_o, ex_pc_add4_o, ex_rs1_data_o, ex_rs2_data_o,
                   ex_imm_o, ex_rs1_o, ex_rs2_o, ex_rd_o, ex_funct3_o, ex_alu_op_o,
                   ex_a_sel_o, ex_b_imm_o, ctrl_now, ex_exc_addr_o};

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc,
                               input logic ready);
    id_instruction_i = instr;
    id_pc_i          = pc;
    id_pc_add4_i     = pc + 32'd4;
    id_ready_i       = ready;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // ctrl = {reg_write, mem_read, mem_write, branch, jal, jalr, illegal}
    vecs[0]  = '{32'h00028333, 32'h0,        1'b0, 5'd6,  3'd0, 4'b0000, 1'b1, 2'b00, 1'b0, 1'b1, 7'b1000000};
    names[0] = "add";
    vecs[1]  = '{32'h40128333, 32'h0,        1'b0, 5'd6,  3'd0, 4'b1000, 1'b1, 2'b00, 1'b0, 1'b1, 7'b1000000};
    names[1] = "sub";
    vecs[2]  = '{32'h40355493, 32'h00000403, 1'b1, 5'd9,  3'd5, 4'b1101, 1'b1, 2'b00, 1'b1, 1'b1, 7'b1000000};
    names[2] = "srai";
    vecs[3]  = '{32'hFFF57493, 32'hFFFFFFFF, 1'b1, 5'd9,  3'd7, 4'b0111, 1'b1, 2'b00, 1'b1, 1'b1, 7'b1000000};
    names[3] = "andi";
    vecs[4]  = '{32'h000013B7, 32'h00001000, 1'b1, 5'd7,  3'd1, 4'b0000, 1'b1, 2'b10, 1'b1, 1'b1, 7'b1000000};
    names[4] = "lui";
    vecs[5]  = '{32'h80000597, 32'h80000000, 1'b1, 5'd11, 3'd0, 4'b0000, 1'b1, 2'b01, 1'b1, 1'b1, 7'b1000000};
    names[5] = "auipc";
    vecs[6]  = '{32'hFE208CE3, 32'hFFFFFFF8, 1'b1, 5'd0,  3'd0, 4'b0000, 1'b0, 2'b00, 1'b0, 1'b0, 7'b0001000};
    names[6] = "beq";
    vecs[7]  = '{32'h001000EF, 32'h00000800, 1'b1, 5'd1,  3'd0, 4'b0000, 1'b1, 2'b00, 1'b0, 1'b0, 7'b1000100};
    names[7] = "jal";
    vecs[8]  = '{32'h00C280E7, 32'h0000000C, 1'b1, 5'd1,  3'd0, 4'b0000, 1'b1, 2'b00, 1'b0, 1'b0, 7'b1000010};
    names[8] = "jalr";
    vecs[9]  = '{32'hFE21AE23, 32'hFFFFFFFC, 1'b1, 5'd0,  3'd2, 4'b0000, 1'b1, 2'b00, 1'b1, 1'b1, 7'b0010000};
    names[9] = "sw";
    vecs[10] = '{32'h00812603, 32'h00000008, 1'b1, 5'd12, 3'd2, 4'b0000, 1'b1, 2'b00, 1'b1, 1'b1, 7'b1100000};
    names[10] = "lw";
    vecs[11] = '{32'h0FF0000F, 32'h0,        1'b0, 5'd0,  3'd0, 4'b0000, 1'b0, 2'b00, 1'b0, 1'b0, 7'b0000000};
    names[11] = "fence";
    vecs[12] = '{32'h00000000, 32'h0,        1'b0, 5'd0,  3'd0, 4'b0000, 1'b0, 2'b00, 1'b0, 1'b0, 7'b0000001};
    names[12] = "zero_insn";
    vecs[13] = '{32'h00028331, 32'h0,        1'b0, 5'd0,  3'd0, 4'b0000, 1'b0, 2'b00, 1'b0, 1'b0, 7'b0000001};
    names[13] = "bad_lowbits";

    // Reset with random inputs for two cycles.
    rst_i = 1'b0;
    for (int c = 0; c < 2; c++) begin
      id_instruction_i = $urandom;
      id_pc_i          = $urandom;
      id_pc_add4_i     = $urandom;
      id_ready_i       = 1'($urandom);
      id_exc_addr_i    = 1'($urandom);
      wb_we_i          = 1'($urandom);
      wb_rd_i          = 5'($urandom);
      wb_data_i        = $urandom;
      stall_i          = 1'($urandom);
      flush_i          = 1'($urandom);
      tick();
    end
    checkOutput("reset_ex_any_set", 32'(|all_ex), 32'd0);
    checkOutput("reset_id_stall", 32'(id_stall_o), 32'd0);

    rst_i         = 1'b1;
    wb_we_i       = 1'b0;
    wb_rd_i       = 5'd0;
    wb_data_i     = 32'd0;
    stall_i       = 1'b0;
    flush_i       = 1'b0;
    id_exc_addr_i = 1'b0;

    // Decode table.
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].instr, 32'h1000 + 32'(i * 4), 1'b1);
      #1;
      checkOutput({names[i], ".id_stall"}, 32'(id_stall_o), 32'd0);
      tick();
      checkOutput({names[i], ".valid"}, 32'(ex_valid_o), 32'd1);
      checkOutput({names[i], ".ctrl"}, 32'(ctrl_now), 32'(vecs[i].ctrl));
      checkOutput({names[i], ".rd"}, 32'(ex_rd_o), 32'(vecs[i].rd));
      checkOutput({names[i], ".funct3"}, 32'(ex_funct3_o), 32'(vecs[i].funct3));
      checkOutput({names[i], ".pc"}, ex_pc_o, 32'h1000 + 32'(i * 4));
      checkOutput({names[i], ".pc_add4"}, ex_pc_add4_o, 32'h1004 + 32'(i * 4));
      if (vecs[i].chk_imm)
        checkOutput({names[i], ".imm"}, ex_imm_o, vecs[i].imm);
      if (vecs[i].chk_alu)
        checkOutput({names[i], ".alu_op"}, 32'(ex_alu_op_o), 32'(vecs[i].alu_op));
      if (vecs[i].chk_sel)
        checkOutput({names[i], ".sel"}, 32'({ex_a_sel_o, ex_b_imm_o}),
                    32'({vecs[i].a_sel, vecs[i].b_imm}));
    end

    // Writeback bypass into add x6,x5,x0, then a plain register-file read.
    applyStimulus(32'h00028333, 32'h1100, 1'b1);
    wb_we_i = 1'b1; wb_rd_i = 5'd5; wb_data_i = 32'h00001234;
    tick();
    checkOutput("bypass.rs1_data", ex_rs1_data_o, 32'h00001234);
    checkOutput("bypass.rs2_data", ex_rs2_data_o, 32'h0);
    checkOutput("bypass.alu_op", 32'(ex_alu_op_o), 32'd0);
    checkOutput("bypass.rd", 32'(ex_rd_o), 32'd6);
    checkOutput("bypass.reg_write", 32'(ex_reg_write_o), 32'd1);
    wb_we_i = 1'b0; wb_data_i = 32'hDEADBEEF;
    applyStimulus(32'h00028333, 32'h1104, 1'b1);
    tick();
    checkOutput("rf_read.rs1_data", ex_rs1_data_o, 32'h00001234);

    // Writes to x0 neither bypass nor stick.
    wb_we_i = 1'b1; wb_rd_i = 5'd0; wb_data_i = 32'h0000FFFF;
    applyStimulus(32'h00000333, 32'h1108, 1'b1);
    tick();
    checkOutput("x0_bypass.rs1_data", ex_rs1_data_o, 32'h0);
    checkOutput("x0_bypass.rs2_data", ex_rs2_data_o, 32'h0);
    wb_we_i = 1'b0;
    applyStimulus(32'h00000333, 32'h110C, 1'b1);
    tick();
    checkOutput("x0_read.rs1_data", ex_rs1_data_o, 32'h0);

    // Load-use: lw x7,4(x1) then addi x8,x7,1.
    applyStimulus(32'h0040A383, 32'h1110, 1'b1);
    tick();
    checkOutput("lu.lw_mem_read", 32'(ex_mem_read_o), 32'd1);
    checkOutput("lu.lw_rd", 32'(ex_rd_o), 32'd7);
    applyStimulus(32'h00138413, 32'h1114, 1'b1);
    #1;
    checkOutput("lu.id_stall_hz", 32'(id_stall_o), 32'd1);
    tick();
    checkOutput("lu.bubble_valid", 32'(ex_valid_o), 32'd0);
    checkOutput("lu.bubble_reg_write", 32'(ex_reg_write_o), 32'd0);
    checkOutput("lu.id_stall_after", 32'(id_stall_o), 32'd0);
    tick();
    checkOutput("lu.addi_valid", 32'(ex_valid_o), 32'd1);
    checkOutput("lu.addi_imm", ex_imm_o, 32'h1);
    checkOutput("lu.addi_rs1", 32'(ex_rs1_o), 32'd7);
    checkOutput("lu.addi_rd", 32'(ex_rd_o), 32'd8);
    checkOutput("lu.addi_pc", ex_pc_o, 32'h1114);

    // lw x7 followed by lui x7,1 does not stall.
    applyStimulus(32'h0040A383, 32'h1120, 1'b1);
    tick();
    applyStimulus(32'h000013B7, 32'h1124, 1'b1);
    #1;
    checkOutput("lu_lui.id_stall", 32'(id_stall_o), 32'd0);
    tick();
    checkOutput("lu_lui.valid", 32'(ex_valid_o), 32'd1);
    checkOutput("lu_lui.imm", ex_imm_o, 32'h00001000);

    // Flush beats stall and hazard.
    applyStimulus(32'h0040A383, 32'h1200, 1'b1);
    tick();
    applyStimulus(32'h00138413, 32'h1204, 1'b1);
    flush_i = 1'b1; stall_i = 1'b1;
    #1;
    checkOutput("prio.id_stall", 32'(id_stall_o), 32'd0);
    tick();
    checkOutput("prio.valid", 32'(ex_valid_o), 32'd0);
    checkOutput("prio.ctrl", 32'(ctrl_now), 32'd0);
    flush_i = 1'b0; stall_i = 1'b0;

    // Stall alone holds ID/EX for three cycles.
    applyStimulus(32'h40128333, 32'h2000, 1'b1);
    tick();
    stall_i = 1'b1;
    applyStimulus(32'hFFF57493, 32'h2004, 1'b1);
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput("hold.valid", 32'(ex_valid_o), 32'd1);
      checkOutput("hold.alu_op", 32'(ex_alu_op_o), 32'b1000);
      checkOutput("hold.rd", 32'(ex_rd_o), 32'd6);
      checkOutput("hold.pc", ex_pc_o, 32'h2000);
    end
    stall_i = 1'b0;
    tick();
    checkOutput("release.alu_op", 32'(ex_alu_op_o), 32'b0111);
    checkOutput("release.pc", ex_pc_o, 32'h2004);

    // Misaligned fetch flag: valid, flagged, no side effects.
    applyStimulus(32'h00812603, 32'h3000, 1'b1);
    id_exc_addr_i = 1'b1;
    tick();
    id_exc_addr_i = 1'b0;
    checkOutput("exc.valid", 32'(ex_valid_o), 32'd1);
    checkOutput("exc.flag", 32'(ex_exc_addr_o), 32'd1);
    checkOutput("exc.side_effects", 32'({ex_reg_write_o, ex_mem_read_o, ex_mem_write_o}), 32'd0);
    checkOutput("exc.rd", 32'(ex_rd_o), 32'd0);

    // Empty IF/ID produces a bubble.
    applyStimulus(32'h00028333, 32'h3004, 1'b0);
    tick();
    checkOutput("not_ready.valid", 32'(ex_valid_o), 32'd0);
    checkOutput("not_ready.reg_write", 32'(ex_reg_write_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
